// File: rtl/correlator_search_ctrl.sv
// ---------------------------------------------------------------------------
// correlator_search_ctrl
//
// Purpose: drives correlator_core through a raster search over the window
// [X_START..X_END] x [Y_START..Y_END]. For each trial the controller holds
// the go level high with stable offsets until the core reports completion.
// It then drops go for one re-arm cycle and updates the running minimum.
// After the last offset pair it reports the best position. A trial that
// never completes within TIMEOUT cycles aborts the search with a sticky
// error flag.
//
// Ports:
//   clk            in   rising-edge clock for all logic
//   reset          in   synchronous, active-high reset
//   start          in   one-cycle request to run a full window search (IDLE only)
//   frame_sel      in   current-frame BRAM half select, latched at start
//   corr_go        out  go level to correlator_core
//   corr_x_offset  out  [5:0] x offset to correlator_core
//   corr_y_offset  out  [5:0] y offset to correlator_core
//   corr_frame_sel out  drives curr_frame_bram_offset_sel
//   corr_sum       in   [15:0] correlator result, valid with corr_done
//   corr_done      in   correlator trial complete (ignored outside RUN)
//   busy           out  search in progress
//   result_valid   out  one-cycle pulse, best_* are final
//   best_x         out  [5:0] x offset of the minimum sum
//   best_y         out  [5:0] y offset of the minimum sum
//   best_sum       out  [15:0] minimum sum found
//   timeout_err    out  sticky: last search aborted on timeout
// ---------------------------------------------------------------------------
module correlator_search_ctrl #(
  parameter int X_START = 16,
  parameter int X_END   = 48,
  parameter int Y_START = 16,
  parameter int Y_END   = 48,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_sel,
  output logic        corr_go,
  output logic [5:0]  corr_x_offset,
  output logic [5:0]  corr_y_offset,
  output logic        corr_frame_sel,
  input  logic [15:0] corr_sum,
  input  logic        corr_done,
  output logic        busy,
  output logic        result_valid,
  output logic [5:0]  best_x,
  output logic [5:0]  best_y,
  output logic [15:0] best_sum,
  output logic        timeout_err
);

  // Wide enough to hold TIMEOUT itself; the counter never counts past it.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [5:0]        X_FIRST    = 6'(X_START);
  localparam logic [5:0]        X_LAST     = 6'(X_END);
  localparam logic [5:0]        Y_FIRST    = 6'(Y_START);
  localparam logic [5:0]        Y_LAST     = 6'(Y_END);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_count;
  logic [15:0]       captured_sum;
  // best_* hold stale values from the previous search until the first trial
  // of a new search lands. This flag says whether they belong to this search.
  logic              best_valid;

  logic              is_better;
  logic              at_x_last;
  logic              at_y_last;

  // Strictly-less comparison keeps the earlier trial on ties. An empty best
  // accepts anything, including 16'hFFFF.
  assign is_better = !best_valid || (captured_sum < best_sum);
  assign at_x_last = (corr_x_offset == X_LAST);
  assign at_y_last = (corr_y_offset == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_count     <= '0;
      captured_sum   <= '0;
      best_valid     <= 1'b0;
      corr_go        <= 1'b0;
      corr_x_offset  <= X_FIRST;
      corr_y_offset  <= Y_FIRST;
      corr_frame_sel <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      best_x         <= '0;
      best_y         <= '0;
      best_sum       <= 16'hFFFF;
      timeout_err    <= 1'b0;
    end else begin
      // result_valid is a pulse; only a transition into DONE raises it.
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            corr_go        <= 1'b1;
            busy           <= 1'b1;
            corr_frame_sel <= frame_sel;
            corr_x_offset  <= X_FIRST;
            corr_y_offset  <= Y_FIRST;
            timeout_err    <= 1'b0;
            best_valid     <= 1'b0;
            wait_count     <= '0;
          end
        end

        RUN: begin
          // Completion wins over timeout when both happen on the same cycle.
          if (corr_done) begin
            captured_sum <= corr_sum;
            corr_go      <= 1'b0;
            state        <= COMPARE;
          end else if (wait_count == WAIT_LIMIT) begin
            // Abort: best_* keep whatever they hold right now.
            corr_go      <= 1'b0;
            timeout_err  <= 1'b1;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            wait_count <= wait_count + WAIT_W'(1);
          end
        end

        COMPARE: begin
          // go is low for exactly this one cycle, which re-arms the core.
          wait_count <= '0;
          if (is_better) begin
            best_sum   <= captured_sum;
            best_x     <= corr_x_offset;
            best_y     <= corr_y_offset;
            best_valid <= 1'b1;
          end
          if (at_x_last && at_y_last) begin
            // Offsets stay on the last position; they reload at next start.
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            // Raster order: x runs fastest, y advances when x wraps.
            if (at_x_last) begin
              corr_x_offset <= X_FIRST;
              corr_y_offset <= corr_y_offset + 6'd1;
            end else begin
              corr_x_offset <= corr_x_offset + 6'd1;
            end
            corr_go <= 1'b1;
            state   <= RUN;
          end
        end

        DONE: begin
          wait_count <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          corr_go <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_correlator_search_ctrl
//
// Purpose: directed bench for correlator_search_ctrl. The main instance uses
// a 2x2 window (0..1, 0..1) with TIMEOUT=8. A second instance uses a 1x1
// window at (63,5). A negedge process plays the correlator_core: it raises
// corr_done three cycles after go rises, answering from a per-test sum table.
// The same process watches go gaps, offset stability and frame select.
// Expected search results are queued when a start is driven and popped when
// result_valid pulses.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_correlator_search_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        reset, start, frame_sel, corr_done;
  logic [15:0] corr_sum;
  logic        corr_go, corr_frame_sel, busy, result_valid, timeout_err;
  logic [5:0]  corr_x_offset, corr_y_offset, best_x, best_y;
  logic [15:0] best_sum;

  // 1x1 window instance
  logic        start1, done1;
  logic [15:0] sum1;
  logic        corr_go1, corr_frame_sel1, busy1, result_valid1, timeout_err1;
  logic [5:0]  corr_x_offset1, corr_y_offset1, best_x1, best_y1;
  logic [15:0] best_sum1;

  correlator_search_ctrl #(
    .X_START(0), .X_END(1), .Y_START(0), .Y_END(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_sel(frame_sel),
    .corr_go(corr_go), .corr_x_offset(corr_x_offset), .corr_y_offset(corr_y_offset),
    .corr_frame_sel(corr_frame_sel), .corr_sum(corr_sum), .corr_done(corr_done),
    .busy(busy), .result_valid(result_valid), .best_x(best_x), .best_y(best_y),
    .best_sum(best_sum), .timeout_err(timeout_err)
  );

  correlator_search_ctrl #(
    .X_START(63), .X_END(63), .Y_START(5), .Y_END(5), .TIMEOUT(8)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .frame_sel(1'b0),
    .corr_go(corr_go1), .corr_x_offset(corr_x_offset1), .corr_y_offset(corr_y_offset1),
    .corr_frame_sel(corr_frame_sel1), .corr_sum(sum1), .corr_done(done1),
    .busy(busy1), .result_valid(result_valid1), .best_x(best_x1), .best_y(best_y1),
    .best_sum(best_sum1), .timeout_err(timeout_err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] sum;
    logic        tmo;
    int          trials;
  } exp_t;

  exp_t        sb[$];

  // core model state
  logic        resp_en, resp_done, force_done, exp_frame;
  logic        prev_go, prev_busy;
  logic [5:0]  hold_x, hold_y;
  logic [15:0] sums [4];
  int          go_cnt, gap, trials_this, rv_count;

  assign corr_done = resp_done | force_done;

  initial begin
    resp_done   = 1'b0;
    corr_sum    = '0;
    prev_go     = 1'b0;
    prev_busy   = 1'b0;
    hold_x      = '0;
    hold_y      = '0;
    go_cnt      = 0;
    gap         = 0;
    trials_this = 0;
    rv_count    = 0;
  end

  always @(negedge clk) begin
    if (reset) begin
      go_cnt    = 0;
      resp_done = 1'b0;
      prev_go   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        trials_this = 0;
        gap         = 0;
      end
      if (busy) check("frame_sel_hold", corr_frame_sel, exp_frame);
      if (corr_go && !prev_go) begin
        if (trials_this > 0) check("go_gap", gap, 1);
        hold_x = corr_x_offset;
        hold_y = corr_y_offset;
        gap    = 0;
      end else if (corr_go) begin
        check("x_stable", corr_x_offset, hold_x);
        check("y_stable", corr_y_offset, hold_y);
      end
      if (!corr_go && busy) gap++;

      resp_done = 1'b0;
      if (corr_go && resp_en) begin
        go_cnt++;
        if (go_cnt == 3) begin
          resp_done = 1'b1;
          corr_sum  = sums[{corr_y_offset[0], corr_x_offset[0]}];
          trials_this++;
        end
      end else begin
        go_cnt = 0;
      end

      if (result_valid) begin
        rv_count++;
        if (sb.size() == 0) begin
          check("unexpected_result", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("result: x=%0d y=%0d sum=%0d tmo=%0d trials=%0d", best_x, best_y, best_sum, timeout_err, trials_this);
          check("best_x", best_x, e.x);
          check("best_y", best_y, e.y);
          check("best_sum", best_sum, e.sum);
          check("timeout_err", timeout_err, e.tmo);
          check("trials", trials_this, e.trials);
        end
      end
      prev_go   = corr_go;
      prev_busy = busy;
    end
  end

  // Inputs change 1 time unit after the falling edge, after the model has run.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rv(input int target, input string tag);
    for (int i = 0; i < 300 && rv_count < target; i++) step();
    check(tag, rv_count, target);
  endtask

  task automatic set_sums(input logic [15:0] a, b, c, d);
    sums[0] = a; sums[1] = b; sums[2] = c; sums[3] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; frame_sel = 1'b0; force_done = 1'b0;
    resp_en = 1'b1; exp_frame = 1'b0;
    start1 = 1'b0; done1 = 1'b0; sum1 = '0;
    set_sums(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) step();

    // reset values
    check("rst_go", corr_go, 0);
    check("rst_x", corr_x_offset, 0);
    check("rst_y", corr_y_offset, 0);
    check("rst_frame", corr_frame_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    check("rst_best_x", best_x, 0);
    check("rst_best_y", best_y, 0);
    check("rst_best_sum", best_sum, 16'hFFFF);
    check("rst_tmo", timeout_err, 0);
    check("rst1_x", corr_x_offset1, 63);
    check("rst1_y", corr_y_offset1, 5);
    reset = 1'b0;
    step();

    // corr_done outside RUN is ignored
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    step();
    check("idle_done_busy", busy, 0);
    check("idle_done_rv", rv_count, 0);

    // A: sums 40,30,30,50 -> (1,0,30); frame_sel toggles; start while busy
    set_sums(16'd40, 16'd30, 16'd30, 16'd50);
    exp_frame = 1'b1;
    frame_sel = 1'b1;
    sb.push_back('{6'd1, 6'd0, 16'd30, 1'b0, 4});
    start = 1'b1;
    step();
    start = 1'b0;
    check("A_busy", busy, 1);
    for (int i = 0; i < 200 && rv_count < 1; i++) begin
      step();
      frame_sel = ~frame_sel;
      start = (i == 4);
    end
    start = 1'b0;
    check("A_done", rv_count, 1);
    step();
    check("A_busy_after", busy, 0);
    repeat (3) step();
    check("A_hold_x", best_x, 1);
    check("A_hold_sum", best_sum, 30);
    check("A_idle_go", corr_go, 0);

    // C: reset during trial 2, then a full rerun with 9,8,7,6 -> (1,1,6)
    set_sums(16'd9, 16'd8, 16'd7, 16'd6);
    exp_frame = 1'b0;
    frame_sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 50 && !(trials_this == 1 && corr_go); i++) step();
    check("C_in_trial2", trials_this, 1);
    reset = 1'b1;
    step();
    check("C_rst_busy", busy, 0);
    check("C_rst_go", corr_go, 0);
    check("C_rst_sum", best_sum, 16'hFFFF);
    reset = 1'b0;
    repeat (3) step();
    check("C_no_rv", rv_count, 1);
    sb.push_back('{6'd1, 6'd1, 16'd6, 1'b0, 4});
    start = 1'b1;
    step();
    start = 1'b0;
    wait_rv(2, "C_done");

    // D: core never answers -> timeout after 9 RUN cycles, best_* held
    step();
    resp_en = 1'b0;
    sb.push_back('{6'd1, 6'd1, 16'd6, 1'b1, 0});
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (rv_count < 3 && cyc < 40) begin
      step();
      cyc++;
    end
    check("D_latency", cyc, 10);
    step();
    check("D_busy_after", busy, 0);
    check("D_tmo_sticky", timeout_err, 1);
    repeat (2) step();
    check("D_tmo_hold", timeout_err, 1);
    resp_en = 1'b1;

    // B: all sums equal -> first trial kept; start clears timeout_err
    set_sums(16'd70, 16'd70, 16'd70, 16'd70);
    sb.push_back('{6'd0, 6'd0, 16'd70, 1'b0, 4});
    start = 1'b1;
    step();
    start = 1'b0;
    check("B_tmo_clear", timeout_err, 0);
    wait_rv(4, "B_done");
    step();

    // 1x1 window: single trial, 16'hFFFF accepted as first best
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("W1_busy", busy1, 1);
    check("W1_go", corr_go1, 1);
    step();
    step();
    done1 = 1'b1;
    sum1  = 16'hFFFF;
    step();
    done1 = 1'b0;
    check("W1_gap", corr_go1, 0);
    step();
    check("W1_rv", result_valid1, 1);
    step();
    $display("result1: x=%0d y=%0d sum=%0h", best_x1, best_y1, best_sum1);
    check("W1_rv_pulse", result_valid1, 0);
    check("W1_busy_end", busy1, 0);
    check("W1_best_x", best_x1, 63);
    check("W1_best_y", best_y1, 5);
    check("W1_best_sum", best_sum1, 16'hFFFF);
    check("W1_tmo", timeout_err1, 0);
    check("W1_frame", corr_frame_sel1, 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
